// File: rtl/servo_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_capture
//  Description : Measures the high time of an incoming servo PWM waveform and
//                converts it to an integer angle without a divider.
//                Flags short/long pulses and loss of signal.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_capture #(
    parameter int MIN_PULSE   = 60000,
    parameter int STEP        = 944,
    parameter int MAX_ANGLE   = 180,
    parameter int LOST_CYCLES = 4000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pwm_in,
    output logic [8:0]  angle,
    output logic [19:0] pulse_width,
    output logic        angle_valid,
    output logic        err_short,
    output logic        err_long,
    output logic        signal_lost
);

    localparam int          c_STEP_W    = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [19:0] c_MIN       = 20'(MIN_PULSE);
    localparam logic [19:0] c_LIMIT     = 20'(MIN_PULSE + STEP * (MAX_ANGLE + 1));
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP - 1);
    localparam logic [21:0] c_LOST      = 22'(LOST_CYCLES);
    localparam logic [21:0] c_PERIOD_MAX = '1;

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_meta;
    logic                r_pwm_s;
    logic                r_armed;
    logic [19:0]         r_width;
    logic [c_STEP_W-1:0] r_step;
    logic [8:0]          r_acc;
    logic [21:0]         r_period;
    logic [8:0]          r_angle;
    logic [19:0]         r_pulse_width;
    logic                r_valid;
    logic                r_short;
    logic                r_long;
    logic                w_start;
    logic                w_inc;
    logic                w_eval;
    logic                w_long;

    // Two-flop synchronizer; r_armed marks that r_meta now reflects the real pin.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_meta  <= 1'b0;
            r_pwm_s <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= pwm_in;
            r_pwm_s <= r_meta;
            r_armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) r_state <= S_SYNC;
        else     r_state <= w_next;
    end

    // Next-state and datapath controls. SYNC leaves only once both synchronizer
    // stages show a settled low, so a pulse already high at reset is skipped.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_inc   = 1'b0;
        w_eval  = 1'b0;
        w_long  = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (r_armed && !r_meta && !r_pwm_s) w_next = S_LOW;
            end
            S_LOW: begin
                if (r_pwm_s) begin
                    w_next  = S_HIGH;
                    w_start = 1'b1;
                end
            end
            S_HIGH: begin
                if (r_width == c_LIMIT) begin
                    w_long = 1'b1;
                    w_next = S_SYNC;
                end else if (r_pwm_s) begin
                    w_inc = 1'b1;
                end else begin
                    w_eval = 1'b1;
                    w_next = S_LOW;
                end
            end
            default: w_next = S_SYNC;
        endcase
    end

    // Width counter plus incremental angle: the step counter runs only beyond
    // MIN_PULSE and bumps the accumulator every STEP cycles, so the accumulator
    // equals floor((W - MIN_PULSE) / STEP) when the pulse ends.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_width       <= '0;
            r_step        <= '0;
            r_acc         <= '0;
            r_angle       <= '0;
            r_pulse_width <= '0;
            r_valid       <= 1'b0;
            r_short       <= 1'b0;
            r_long        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_short <= 1'b0;
            r_long  <= w_long;
            if (w_start) begin
                r_width <= 20'd1;
                r_step  <= '0;
                r_acc   <= '0;
            end else if (w_inc) begin
                r_width <= r_width + 20'd1;
                if (r_width >= c_MIN) begin
                    if (r_step == c_STEP_LAST) begin
                        r_step <= '0;
                        r_acc  <= r_acc + 9'd1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
            end
            if (w_eval) begin
                if (r_width < c_MIN) begin
                    r_short <= 1'b1;
                end else begin
                    r_angle       <= r_acc;
                    r_pulse_width <= r_width;
                    r_valid       <= 1'b1;
                end
            end
        end
    end

    // Saturating cycles-since-last-rising-edge counter for loss-of-signal.
    always_ff @(posedge clk) begin
        if (clr || w_start)              r_period <= '0;
        else if (r_period != c_PERIOD_MAX) r_period <= r_period + 22'd1;
    end

    assign angle       = r_angle;
    assign pulse_width = r_pulse_width;
    assign angle_valid = r_valid;
    assign err_short   = r_short;
    assign err_long    = r_long;
    assign signal_lost = (r_period >= c_LOST);

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_capture
//  Description : Directed self-checking bench for servo_pwm_capture, run with
//                scaled-down parameters (MIN 60, STEP 4, LIMIT 784, LOST 2000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_capture;

    localparam int MIN_PULSE   = 60;
    localparam int STEP        = 4;
    localparam int MAX_ANGLE   = 180;
    localparam int LOST_CYCLES = 2000;
    localparam int LIMIT       = MIN_PULSE + STEP * (MAX_ANGLE + 1);  // 784

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        pwm_in = 1'b0;
    logic [8:0]  angle;
    logic [19:0] pulse_width;
    logic        angle_valid;
    logic        err_short;
    logic        err_long;
    logic        signal_lost;

    servo_pwm_capture #(
        .MIN_PULSE  (MIN_PULSE),
        .STEP       (STEP),
        .MAX_ANGLE  (MAX_ANGLE),
        .LOST_CYCLES(LOST_CYCLES)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pwm_in     (pwm_in),
        .angle      (angle),
        .pulse_width(pulse_width),
        .angle_valid(angle_valid),
        .err_short  (err_short),
        .err_long   (err_long),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_valid = 0, n_short = 0, n_long = 0;
    int   valid_cyc = 0, long_cyc = 0;
    int   n_overlap = 0, n_consec = 0;
    logic prev_any = 1'b0;
    int   n_checks = 0, n_pass = 0;
    int   rise_cyc = 0, fall_cyc = 0;
    int   v0, s0, l0;

    // Cycle index; the value held during a cycle is the stamp for that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts, timestamps, exclusivity and spacing.
    always @(posedge clk) begin
        if (angle_valid === 1'b1) begin n_valid <= n_valid + 1; valid_cyc <= cyc; end
        if (err_short === 1'b1) n_short <= n_short + 1;
        if (err_long === 1'b1) begin n_long <= n_long + 1; long_cyc <= cyc; end
        if ((int'(angle_valid === 1'b1) + int'(err_short === 1'b1) + int'(err_long === 1'b1)) > 1)
            n_overlap <= n_overlap + 1;
        if (prev_any && ((angle_valid | err_short | err_long) === 1'b1)) n_consec <= n_consec + 1;
        prev_any <= ((angle_valid | err_short | err_long) === 1'b1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive a pulse of exactly h synchronized high cycles, then idle low.
    task automatic pulse(input int h);
        @(negedge clk);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (h) @(negedge clk);
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic snap();
        v0 = n_valid; s0 = n_short; l0 = n_long;
    endtask

    task automatic run_valid(input int h, input int ang);
        snap();
        pulse(h);
        chk($sformatf("valid_cnt_w%0d", h), n_valid, v0 + 1);
        chk($sformatf("valid_lat_w%0d", h), valid_cyc, fall_cyc + 3);
        chk($sformatf("angle_w%0d", h), angle, ang);
        chk($sformatf("pw_w%0d", h), pulse_width, h);
        chk($sformatf("no_short_w%0d", h), n_short, s0);
        chk($sformatf("no_long_w%0d", h), n_long, l0);
    endtask

    task automatic run_short(input int h, input int keep_ang, input int keep_pw);
        snap();
        pulse(h);
        chk($sformatf("short_cnt_w%0d", h), n_short, s0 + 1);
        chk($sformatf("short_novalid_w%0d", h), n_valid, v0);
        chk($sformatf("short_angle_w%0d", h), angle, keep_ang);
        chk($sformatf("short_pw_w%0d", h), pulse_width, keep_pw);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_angle", angle, 0);
        chk("rst_pw", pulse_width, 0);
        chk("rst_strobes", {angle_valid, err_short, err_long}, 0);
        chk("rst_lost", signal_lost, 0);
        clr = 1'b0;
        repeat (5) @(negedge clk);

        // Decode boundaries: minimum, step wrap, maximum, mid-range.
        run_valid(MIN_PULSE, 0);
        run_valid(MIN_PULSE + STEP - 1, 0);
        run_valid(MIN_PULSE + STEP, 1);
        run_valid(LIMIT - 1, MAX_ANGLE);
        run_valid(MIN_PULSE + STEP * 90, 90);

        // Short pulse and single-cycle glitch keep the last result.
        run_short(MIN_PULSE - 1, 90, MIN_PULSE + STEP * 90);
        run_short(1, 90, MIN_PULSE + STEP * 90);

        // Line held high past LIMIT.
        snap();
        @(negedge clk);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (900) @(negedge clk);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);
        chk("long_cnt", n_long, l0 + 1);
        chk("long_lat", long_cyc, rise_cyc + 3 + LIMIT);
        chk("long_novalid", n_valid, v0);
        chk("long_noshort", n_short, s0);
        chk("long_angle", angle, 90);
        run_valid(MIN_PULSE + STEP * 10, 10);

        // Reset in the middle of a pulse; the tail must not be measured.
        snap();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("clr_angle", angle, 0);
        chk("clr_pw", pulse_width, 0);
        chk("clr_lost", signal_lost, 0);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_novalid", n_valid, v0);
        chk("clr_noshort", n_short, s0);
        chk("clr_nolong", n_long, l0);
        chk("clr_angle_hold", angle, 0);
        run_valid(MIN_PULSE + STEP * 45, 45);

        // Loss of signal after the last rising edge, then recovery.
        while (cyc < rise_cyc + 3 + LOST_CYCLES - 1) @(negedge clk);
        chk("lost_before", signal_lost, 0);
        @(negedge clk);
        chk("lost_assert", signal_lost, 1);
        @(negedge clk);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (2) @(negedge clk);
        chk("lost_hold", signal_lost, 1);
        @(negedge clk);
        chk("lost_clear", signal_lost, 0);
        repeat (70) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);

        chk("strobe_overlap", n_overlap, 0);
        chk("strobe_consec", n_consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
